majority_vote_seq: RTL and testbench
====================================

Name: majority_vote_seq

Overview:
- Bit-serial triple-modular-redundancy voting controller.
- Captures three WIDTH-bit channel words on a start handshake. Over WIDTH cycles it feeds one bit per channel into a single shared 3-input majority cell, LSB first.
- Accumulates the voted word, a per-bit disagreement mask, a disagreement count and per-channel fault flags, then reports them with a one-cycle done pulse.
- Sits between redundant producers and the consumer that needs a voted value plus fault status.

Parameters:
- WIDTH, 8, bits per channel word and number of RUN cycles; legal range 2..32.
- CW, $clog2(WIDTH+1), width of err_count (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- ch_a  in  WIDTH  channel A word, captured when start is accepted.
- ch_b  in  WIDTH  channel B word, captured when start is accepted.
- ch_c  in  WIDTH  channel C word, captured when start is accepted.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results valid from this cycle.
- result  out  WIDTH  voted word.
- mismatch  out  WIDTH  bit i=1 when the three channels were not unanimous at bit i.
- err_count  out  CW  popcount of mismatch.
- fault  out  3  bit0=A, bit1=B, bit2=C; set if that channel differed from the majority at any bit.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0; result, mismatch, err_count, fault all 0.
  - Operand shift registers, accumulators and bit counter cleared.
  - Reset overrides start in the same cycle.
- States: IDLE, RUN, DONE.
  - IDLE: on start=1, capture ch_a/ch_b/ch_c into shift registers, clear accumulators and bit counter, go to RUN.
  - RUN: each cycle, vote bit idx (LSB of each shift register) through the majority cell.
    - Shift the voted bit into the result accumulator at position idx.
    - mismatch bit idx = NOT(a==b==c).
    - Increment the count accumulator on mismatch.
    - OR into the fault accumulator: (a!=maj), (b!=maj), (c!=maj).
    - Shift operands right and increment idx.
    - When idx==WIDTH-1, go to DONE.
  - DONE: done=1 for exactly this cycle; output registers load from the accumulators on entry to DONE. Go to IDLE unconditionally.
- Timing and latency:
  - Start sampled at edge 0; busy=1 from cycle 1; RUN occupies cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1; idle again in cycle WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- Handshake:
  - start is ignored while busy (RUN or DONE); no queuing.
  - A start held high continuously retriggers in each IDLE cycle.
  - ch_* values are don't-care except in the accept cycle.
- Output stability: result, mismatch, err_count and fault change only on DONE entry or reset, and hold between operations.
- Arithmetic:
  - err_count saturation is not needed, since its maximum is WIDTH and CW covers it.
  - Bit counter width is $clog2(WIDTH) and must not overflow; the wrap to 0 occurs only on the DONE transition.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, and outputs are cleared to 0 (not held).
- Single-fault property: exactly one channel differing at any set of bits gives fault one-hot, and result equals the other two channels.

Decomposition:
- Shared package majority_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding).
  - FAULT_A/B/C bit-index constants.
- One sub-module: a single instance of the team's existing 3-input majority cell majoritycir (inp={a,b,c}, out=maj). The sequencer must not re-implement the vote inline.

Test Plan (WIDTH=8):
1. ch_a=ch_b=ch_c=8'hA5, start at cycle 0 -> done only in cycle 9; result=8'hA5, mismatch=8'h00, err_count=0, fault=3'b000; busy high cycles 1-9.
2. ch_a=8'hFF, ch_b=8'h00, ch_c=8'h0F -> result=8'h0F, mismatch=8'hFF, err_count=8, fault=3'b011.
3. ch_a=8'h3C, ch_b=8'h3C, ch_c=8'h3D -> result=8'h3C, mismatch=8'h01, err_count=1, fault=3'b100.
4. Start accepted with values from test 2; start re-pulsed with other data at cycle 4 -> ignored, results equal test 2. Then start held high -> next done at cycle 19, i.e. a 10-cycle period.
5. Run test 3, then a new start with test 2 data, then rst=1 at cycle 5 of the second run -> next cycle busy=0, outputs all 0, no done. A subsequent start with 8'hA5 x3 completes normally.
6. rst=1 and start=1 in the same cycle -> stays IDLE, busy=0, no done within 12 cycles.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared types and constants for the bit-serial TMR voting controller.
package majority_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions of each channel inside the fault flag vector.
    localparam int FAULT_A = 0;
    localparam int FAULT_B = 1;
    localparam int FAULT_C = 2;

endpackage

// File: rtl/majoritycir.sv
// Three-input majority cell: out is high when at least two of the inputs are high.
module majoritycir (
    input  logic [2:0] inp,
    output logic       out
);

    assign out = (inp[2] & inp[1]) | (inp[2] & inp[0]) | (inp[1] & inp[0]);

endmodule

// File: rtl/majority_vote_seq.sv
// Bit-serial triple-modular-redundancy voter: one shared majority cell walks the
// three captured words LSB first and reports voted word plus fault status.
module majority_vote_seq
    import majority_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ch_a,
    input  logic [WIDTH-1:0] ch_b,
    input  logic [WIDTH-1:0] ch_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mismatch,
    output logic [CW-1:0]    err_count,
    output logic [2:0]       fault
);

    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    state_t           state_r;
    logic [WIDTH-1:0] sa_r, sb_r, sc_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] acc_res_r, acc_mis_r;
    logic [CW-1:0]    acc_cnt_r;
    logic [2:0]       acc_flt_r;

    logic             a_s, b_s, c_s, maj_s, mis_s;
    logic [WIDTH-1:0] res_nxt_s, mis_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [2:0]       flt_nxt_s;

    assign a_s = sa_r[0];
    assign b_s = sb_r[0];
    assign c_s = sc_r[0];

    majoritycir u_maj (
        .inp ({a_s, b_s, c_s}),
        .out (maj_s)
    );

    // Accumulator values after folding in the current bit; also feed the outputs on DONE entry.
    always_comb begin
        mis_s              = ~((a_s == b_s) && (b_s == c_s));
        res_nxt_s          = acc_res_r;
        res_nxt_s[idx_r]   = maj_s;
        mis_nxt_s          = acc_mis_r;
        mis_nxt_s[idx_r]   = mis_s;
        cnt_nxt_s          = acc_cnt_r + CW'(mis_s);
        flt_nxt_s          = acc_flt_r;
        flt_nxt_s[FAULT_A] = acc_flt_r[FAULT_A] | (a_s ^ maj_s);
        flt_nxt_s[FAULT_B] = acc_flt_r[FAULT_B] | (b_s ^ maj_s);
        flt_nxt_s[FAULT_C] = acc_flt_r[FAULT_C] | (c_s ^ maj_s);
    end

    // Sequencer: capture on start, vote one bit per cycle, publish results with a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            sa_r      <= {WIDTH{1'b0}};
            sb_r      <= {WIDTH{1'b0}};
            sc_r      <= {WIDTH{1'b0}};
            idx_r     <= {IW{1'b0}};
            acc_res_r <= {WIDTH{1'b0}};
            acc_mis_r <= {WIDTH{1'b0}};
            acc_cnt_r <= {CW{1'b0}};
            acc_flt_r <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= {WIDTH{1'b0}};
            mismatch  <= {WIDTH{1'b0}};
            err_count <= {CW{1'b0}};
            fault     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_r      <= ch_a;
                        sb_r      <= ch_b;
                        sc_r      <= ch_c;
                        idx_r     <= {IW{1'b0}};
                        acc_res_r <= {WIDTH{1'b0}};
                        acc_mis_r <= {WIDTH{1'b0}};
                        acc_cnt_r <= {CW{1'b0}};
                        acc_flt_r <= 3'b000;
                        busy      <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                RUN: begin
                    sa_r      <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r      <= {1'b0, sb_r[WIDTH-1:1]};
                    sc_r      <= {1'b0, sc_r[WIDTH-1:1]};
                    acc_res_r <= res_nxt_s;
                    acc_mis_r <= mis_nxt_s;
                    acc_cnt_r <= cnt_nxt_s;
                    acc_flt_r <= flt_nxt_s;
                    if (idx_r == IDX_LAST) begin
                        idx_r     <= {IW{1'b0}};
                        state_r   <= DONE;
                        done      <= 1'b1;
                        result    <= res_nxt_s;
                        mismatch  <= mis_nxt_s;
                        err_count <= cnt_nxt_s;
                        fault     <= flt_nxt_s;
                    end else begin
                        idx_r     <= idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_majority_vote_seq.sv
// Scoreboard bench for majority_vote_seq: directed cases followed by randomized traffic.
module tb_majority_vote_seq;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] mis;
        logic [CW-1:0]    cnt;
        logic [2:0]       flt;
    } exp_t;

    logic             clk, rst, start;
    logic [WIDTH-1:0] ch_a, ch_b, ch_c;
    logic             busy, done;
    logic [WIDTH-1:0] result, mismatch;
    logic [CW-1:0]    err_count;
    logic [2:0]       fault;

    majority_vote_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch_a      (ch_a),
        .ch_b      (ch_b),
        .ch_c      (ch_c),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mismatch  (mismatch),
        .err_count (err_count),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   rem    = 0;
    bit   exp_busy = 1'b0;
    bit   exp_done = 1'b0;
    exp_t held     = '0;
    exp_t q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference vote by counting ones per bit position.
    function automatic exp_t vote_ref(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [WIDTH-1:0] c);
        exp_t e;
        int   n;
        bit   m;
        e = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            m = (n >= 2);
            e.res[i] = m;
            if (n == 1 || n == 2) begin
                e.mis[i] = 1'b1;
                e.cnt    = e.cnt + CW'(1);
            end
            if (a[i] != m) e.flt[0] = 1'b1;
            if (b[i] != m) e.flt[1] = 1'b1;
            if (c[i] != m) e.flt[2] = 1'b1;
        end
        return e;
    endfunction

    // Timing model: an accepted request keeps the block busy for WIDTH+1 cycles, the last one being done.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rem  = 0;
            q.delete();
            held = '0;
        end else if (rem > 0) begin
            rem--;
        end else if (start) begin
            q.push_back(vote_ref(ch_a, ch_b, ch_c));
            rem = WIDTH + 1;
        end
        exp_busy = (rem > 0);
        exp_done = (rem == 1);
    end

    // Monitor: pops an expected result whenever the DUT pulses done, checks everything every cycle.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        if (done) begin
            if (q.size() == 0) check("done_without_request", 32'(1), 32'(0));
            else held = q.pop_front();
        end
        check("result",    32'(result),    32'(held.res));
        check("mismatch",  32'(mismatch),  32'(held.mis));
        check("err_count", 32'(err_count), 32'(held.cnt));
        check("fault",     32'(fault),     32'(held.flt));
    end

    task automatic drive(bit s, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [WIDTH-1:0] c, bit r);
        start = s;
        ch_a  = a;
        ch_b  = b;
        ch_c  = c;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] a, b, c;
        int mode;
        start = 1'b0; ch_a = 8'h00; ch_b = 8'h00; ch_c = 8'h00; rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(1);

        // Unanimous, full disagreement, single faulty channel.
        drive(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0); idle(11);
        drive(1'b1, 8'hFF, 8'h00, 8'h0F, 1'b0); idle(11);
        drive(1'b1, 8'h3C, 8'h3C, 8'h3D, 1'b0); idle(11);

        // Start while busy is ignored, then a held start retriggers every WIDTH+2 cycles.
        drive(1'b1, 8'hFF, 8'h00, 8'h0F, 1'b0); idle(2);
        drive(1'b1, 8'h12, 8'h34, 8'h56, 1'b0); idle(8);
        for (int i = 0; i < 25; i++) drive(1'b1, 8'(i * 7), 8'(i * 13), 8'(i * 29), 1'b0);
        idle(12);

        // Reset in the middle of a run aborts it; the next run completes normally.
        drive(1'b1, 8'h3C, 8'h3C, 8'h3D, 1'b0); idle(11);
        drive(1'b1, 8'hFF, 8'h00, 8'h0F, 1'b0); idle(3);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1); idle(2);
        drive(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0); idle(11);

        // Reset wins over a simultaneous start.
        drive(1'b1, 8'hA5, 8'h5A, 8'hFF, 1'b1); idle(12);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 2);
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            if (mode == 1) begin
                b = a; c = a;
            end else if (mode == 2) begin
                case ($urandom_range(0, 2))
                    0:       begin b = a; c = a; a = a ^ 8'($urandom); end
                    1:       begin c = a; b = a ^ 8'($urandom); end
                    default: begin b = a; c = a ^ 8'($urandom); end
                endcase
            end
            drive($urandom_range(0, 3) == 0, a, b, c, $urandom_range(0, 99) == 0);
        end
        idle(12);

        check("queue_empty", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
